match_queue: RTL and testbench

- Parametrised synchronous FIFO queue with a built-in multi-mode search comparator.
- Successor to the single-pair equality comparator: generalises data width, adds storage depth, and compares a search key against every valid queue entry in parallel.
- Adds selectable compare modes and a registered, priority-encoded match result.
- Used by queue-management logic to locate the oldest entry meeting a condition without draining the queue.

---
 rtl/match_queue.sv | 111 +++++++++++
 tb/tb_match_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/match_queue.sv
// rtl/match_queue.sv - FIFO queue with a parallel multi-mode search comparator
// Search looks at the contents present before the same edge's push/pop.
module match_queue #(
    parameter int numOfBit = 10,
    parameter int DEPTH    = 8,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Push,
    input  logic [numOfBit-1:0] DataIn,
    input  logic                Pop,
    output logic [numOfBit-1:0] DataOut,
    output logic                Full,
    output logic                Empty,
    output logic [ADDR_W:0]     Count,
    output logic                Overflow,
    output logic                Underflow,
    input  logic                SearchValid,
    input  logic [numOfBit-1:0] SearchKey,
    input  logic [1:0]          Mode,
    output logic                MatchValid,
    output logic                MatchFound,
    output logic [ADDR_W-1:0]   MatchIndex
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic [numOfBit-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   head;
    logic [ADDR_W-1:0]   tail;
    logic                push_ok;
    logic                pop_ok;
    logic [DEPTH-1:0]    hit;
    logic                any_hit;
    logic [ADDR_W-1:0]   first_hit;

    assign Full    = (Count == FULL_COUNT);
    assign Empty   = (Count == '0);
    // A full queue still takes a push when the same edge frees a slot.
    assign push_ok = Push && (!Full || Pop);
    assign pop_ok  = Pop && !Empty;

    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [numOfBit-1:0] entry;
            entry = mem[head + ADDR_W'(i)];
            if ((ADDR_W+1)'(i) < Count) begin
                unique case (Mode)
                    2'b00:   hit[i] = (entry == SearchKey);
                    2'b01:   hit[i] = (entry < SearchKey);
                    2'b10:   hit[i] = (entry > SearchKey);
                    default: hit[i] = 1'b0;
                endcase
            end
        end
    end

    // Descending scan so the lowest (oldest) hitting offset wins.
    always_comb begin
        any_hit   = |hit;
        first_hit = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                first_hit = ADDR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= DataIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            Count      <= '0;
            DataOut    <= '0;
            Overflow   <= 1'b0;
            Underflow  <= 1'b0;
            MatchValid <= 1'b0;
            MatchFound <= 1'b0;
            MatchIndex <= '0;
        end else begin
            Overflow   <= Push && !push_ok;
            Underflow  <= Pop && !pop_ok;
            MatchValid <= SearchValid;
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop_ok) begin
                head    <= head + 1'b1;
                DataOut <= mem[head];
            end
            if (push_ok && !pop_ok) begin
                Count <= Count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                Count <= Count - 1'b1;
            end
            if (SearchValid) begin
                MatchFound <= any_hit;
                MatchIndex <= first_hit;
            end
        end
    end

endmodule

// File: tb/tb_match_queue.sv
// tb/tb_match_queue.sv - directed self-checking bench for match_queue
module tb_match_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Push = 1'b0;
    logic [9:0] DataIn = '0;
    logic       Pop = 1'b0;
    logic [9:0] DataOut;
    logic       Full;
    logic       Empty;
    logic [3:0] Count;
    logic       Overflow;
    logic       Underflow;
    logic       SearchValid = 1'b0;
    logic [9:0] SearchKey = '0;
    logic [1:0] Mode = '0;
    logic       MatchValid;
    logic       MatchFound;
    logic [2:0] MatchIndex;

    int checks = 0;
    int failures = 0;

    match_queue #(.numOfBit(10), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .Push(Push), .DataIn(DataIn), .Pop(Pop), .DataOut(DataOut),
        .Full(Full), .Empty(Empty), .Count(Count),
        .Overflow(Overflow), .Underflow(Underflow),
        .SearchValid(SearchValid), .SearchKey(SearchKey), .Mode(Mode),
        .MatchValid(MatchValid), .MatchFound(MatchFound), .MatchIndex(MatchIndex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        Push = 1'b0;
        Pop = 1'b0;
        SearchValid = 1'b0;
    endtask

    task automatic do_push(input int d);
        Push = 1'b1;
        DataIn = 10'(d);
        cycle();
    endtask

    task automatic do_pop();
        Pop = 1'b1;
        cycle();
    endtask

    task automatic do_search(input int m, input int k);
        SearchValid = 1'b1;
        Mode = 2'(m);
        SearchKey = 10'(k);
        cycle();
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", Empty, 1);
        check("rst_full", Full, 0);
        check("rst_count", Count, 0);
        check("rst_dataout", DataOut, 0);
        check("rst_matchvalid", MatchValid, 0);
        check("rst_overflow", Overflow, 0);
        rst_n = 1'b1;
        cycle();

        // basic push/pop
        do_push(3); do_push(7); do_push(9);
        check("p3_count", Count, 3);
        check("p3_empty", Empty, 0);
        do_pop();
        check("pop1_data", DataOut, 3);
        check("pop1_count", Count, 2);
        do_pop(); do_pop();
        check("pop3_data", DataOut, 9);
        check("pop3_empty", Empty, 1);

        // fill, overflow, push+pop while full
        for (int i = 1; i <= 8; i++) do_push(i);
        check("fill_full", Full, 1);
        check("fill_count", Count, 8);
        do_push(99);
        check("ovf_pulse", Overflow, 1);
        check("ovf_count", Count, 8);
        cycle();
        check("ovf_clear", Overflow, 0);
        Push = 1'b1; DataIn = 10'd9; Pop = 1'b1;
        cycle();
        check("fullpp_data", DataOut, 1);
        check("fullpp_full", Full, 1);
        check("fullpp_ovf", Overflow, 0);

        // drain and underflow
        for (int i = 2; i <= 9; i++) begin
            do_pop();
            check("drain_data", DataOut, i);
        end
        check("drain_empty", Empty, 1);
        do_pop();
        check("unf_pulse", Underflow, 1);
        check("unf_data", DataOut, 9);

        // push+pop while empty: push wins, pop rejected, no fall-through
        Push = 1'b1; DataIn = 10'd42; Pop = 1'b1;
        cycle();
        check("emptypp_count", Count, 1);
        check("emptypp_unf", Underflow, 1);
        check("emptypp_data", DataOut, 9);
        do_pop();
        check("emptypp_pop", DataOut, 42);

        // search on empty queue
        do_search(0, 42);
        check("se_valid", MatchValid, 1);
        check("se_found", MatchFound, 0);
        check("se_index", MatchIndex, 0);

        // search modes over 15,0,7,8,8
        do_push(15); do_push(0); do_push(7); do_push(8); do_push(8);
        check("sm_vclear", MatchValid, 0);
        do_search(0, 8);
        check("eq8_valid", MatchValid, 1);
        check("eq8_found", MatchFound, 1);
        check("eq8_index", MatchIndex, 3);
        do_search(0, 6);
        check("eq6_found", MatchFound, 0);
        check("eq6_index", MatchIndex, 0);
        do_search(1, 7);
        check("lt7_found", MatchFound, 1);
        check("lt7_index", MatchIndex, 1);
        do_search(2, 7);
        check("gt7_found", MatchFound, 1);
        check("gt7_index", MatchIndex, 0);
        cycle();
        check("hold_valid", MatchValid, 0);
        check("hold_found", MatchFound, 1);
        do_search(3, 8);
        check("m11_found", MatchFound, 0);
        // search sees contents before the same-edge push
        Push = 1'b1; DataIn = 10'd1000;
        do_search(0, 1000);
        check("pre_push_found", MatchFound, 0);
        do_search(0, 1000);
        check("post_push_index", MatchIndex, 5);
        do_search(2, 999);
        check("wide_gt_index", MatchIndex, 5);

        // wrap test from a fresh reset
        rst_n = 1'b0;
        #1;
        check("rst2_count", Count, 0);
        check("rst2_matchfound", MatchFound, 0);
        rst_n = 1'b1;
        cycle();
        for (int i = 0; i < 6; i++) begin
            do_push(i + 50);
            do_pop();
        end
        check("wrap_pre_empty", Empty, 1);
        do_push(100); do_push(200); do_push(300); do_push(400);
        do_search(0, 300);
        check("wrap_found", MatchFound, 1);
        check("wrap_index", MatchIndex, 2);
        do_search(0, 400);
        check("wrap_index2", MatchIndex, 3);

        // asynchronous reset mid-search
        SearchValid = 1'b1; Mode = 2'd0; SearchKey = 10'd100;
        @(posedge clk);
        #1;
        check("mid_valid", MatchValid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", MatchValid, 0);
        check("arst_count", Count, 0);
        check("arst_empty", Empty, 1);
        SearchValid = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
